// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB register-bank responder with programmable wait states
// Define APB_SLVERR_EN to raise Pslverr on misses and writes to the read-only ID register.
module apb_slave_regfile #(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] ID_VALUE    = 32'hAB2A_0001
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_READY} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic        setup, complete, enter_ready, leave_ready;

  logic        cap_write, cap_hit;
  logic [5:0]  cap_idx;
  logic [31:0] cap_wdata;

  logic [31:0] offset;
  logic        live_hit;
  logic [5:0]  live_idx;
  logic        sel_hit, sel_write, err_sel, wr_en;
  logic [5:0]  sel_idx;
  logic [31:0] rd_val;

  logic [31:0] regs [1:NUM_REGS-1];

  assign offset   = Paddr - BASE_ADDR;
  assign live_hit = (offset < 32'(NUM_REGS * 4)) && (Paddr[1:0] == 2'b00);
  assign live_idx = offset[7:2];

  // With zero wait states READY is entered on the setup edge itself, before the
  // capture registers are loaded, so the response must come from the live bus.
  assign sel_hit   = (state == ST_IDLE) ? live_hit : cap_hit;
  assign sel_idx   = (state == ST_IDLE) ? live_idx : cap_idx;
  assign sel_write = (state == ST_IDLE) ? Pwrite   : cap_write;

  always_comb begin
`ifdef APB_SLVERR_EN
    err_sel = !sel_hit || (sel_write && (sel_idx == 6'd0));
`else
    err_sel = 1'b0;
`endif
  end

  always_comb begin
    rd_val = '0;
    if (sel_idx == 6'd0) rd_val = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (sel_idx == i[5:0]) rd_val = regs[i];
    end
    if (!sel_hit) rd_val = '0;
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    setup       = 1'b0;
    complete    = 1'b0;
    enter_ready = 1'b0;
    leave_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Psel && !Penable) begin
          setup = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nx    = ST_READY;
            enter_ready = 1'b1;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (!Psel) begin
          state_nx = ST_IDLE;
        end else if (cnt == 4'd1) begin
          state_nx    = ST_READY;
          enter_ready = 1'b1;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_READY: begin
        if (!Psel) begin
          state_nx    = ST_IDLE;
          leave_ready = 1'b1;
        end else if (Penable && Pready) begin
          state_nx    = ST_IDLE;
          complete    = 1'b1;
          leave_ready = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      cap_write <= 1'b0;
      cap_hit   <= 1'b0;
      cap_idx   <= '0;
      cap_wdata <= '0;
    end else if (setup) begin
      cap_write <= Pwrite;
      cap_hit   <= live_hit;
      cap_idx   <= live_idx;
      cap_wdata <= Pwdata;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
      Prdata  <= '0;
    end else if (enter_ready) begin
      Pready  <= 1'b1;
      Pslverr <= err_sel;
      if (!sel_write) Prdata <= rd_val;
    end else if (leave_ready) begin
      Pready  <= 1'b0;
      Pslverr <= 1'b0;
    end
  end

  assign wr_en = complete && cap_write && cap_hit && (cap_idx != 6'd0);

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_en && (cap_idx == i[5:0])) regs[i] <= cap_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - scoreboard bench for apb_slave_regfile, zero and three wait states
module tb_apb_slave_regfile;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ID   = 32'hAB2A_0001;
  localparam int          NREG = 8;
`ifdef APB_SLVERR_EN
  localparam bit SLV = 1'b1;
`else
  localparam bit SLV = 1'b0;
`endif

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic [1:0]  psel;
  logic        Penable, Pwrite;
  logic [31:0] Paddr, Pwdata;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3, pslverr0, pslverr3;
  logic        dsel;
  logic [31:0] obs_prdata;
  logic        obs_pready, obs_pslverr;

  always #5 Hclk = ~Hclk;

  apb_slave_regfile #(.NUM_REGS(NREG), .WAIT_STATES(0), .BASE_ADDR(BASE), .ID_VALUE(ID)) u_dut0 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Psel(psel[0]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata0), .Pready(pready0), .Pslverr(pslverr0));

  apb_slave_regfile #(.NUM_REGS(NREG), .WAIT_STATES(3), .BASE_ADDR(BASE), .ID_VALUE(ID)) u_dut3 (
    .Hclk(Hclk), .Hresetn(Hresetn), .Psel(psel[1]), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata3), .Pready(pready3), .Pslverr(pslverr3));

  assign obs_prdata  = dsel ? prdata3  : prdata0;
  assign obs_pready  = dsel ? pready3  : pready0;
  assign obs_pslverr = dsel ? pslverr3 : pslverr0;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] model [2][NREG];
  logic [31:0] last_rd [2];

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = '0;
      for (int r = 0; r < NREG; r++) model[d][r] = '0;
    end
  endtask

  task automatic predict(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] off;
    logic        hit;
    int          idx;
    exp_t        e;
    off   = addr - BASE;
    hit   = (off < NREG * 4) && (addr[1:0] == 2'b00);
    idx   = int'(off[7:2]);
    e.lat = (d == 1) ? 4 : 1;
    e.err = SLV && (!hit || (wr && idx == 0));
    if (!wr) last_rd[d] = !hit ? 32'h0 : ((idx == 0) ? ID : model[d][idx]);
    else if (hit && idx != 0) model[d][idx] = wdata;
    e.data = last_rd[d];
    sbq.push_back(e);
  endtask

  // Starts at #1 after an edge and ends #1 after the completion edge with the bus idle,
  // so consecutive calls produce back-to-back transfers.
  task automatic xfer(input string tag, input int d, input logic wr,
                      input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int          lat;
    bit          done;
    logic [31:0] rd;
    logic        er;
    rd = 'x;
    er = 1'bx;
    predict(d, wr, addr, wdata);
    dsel    = (d == 1);
    psel    = (d == 1) ? 2'b10 : 2'b01;
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = addr;
    Pwdata  = wdata;
    @(posedge Hclk);
    #1 Penable = 1'b1;
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      lat++;
      @(negedge Hclk);
      if (obs_pready) begin
        done = 1'b1;
        rd   = obs_prdata;
        er   = obs_pslverr;
      end
      @(posedge Hclk);
      #1;
    end
    Penable = 1'b0;
    psel    = 2'b00;
    e = sbq.pop_front();
    check_eq({tag, "_lat"}, lat, e.lat);
    check_eq({tag, "_data"}, rd, e.data);
    check_eq({tag, "_err"}, {31'b0, er}, {31'b0, e.err});
  endtask

  initial begin
    Hresetn = 1'b0;
    psel    = 2'b00;
    Penable = 1'b0;
    Pwrite  = 1'b0;
    Paddr   = '0;
    Pwdata  = '0;
    dsel    = 1'b0;
    clear_model();
    repeat (2) @(posedge Hclk);
    #1;
    check_eq("rst_pready0", {31'b0, pready0}, 32'h0);
    check_eq("rst_pslverr0", {31'b0, pslverr0}, 32'h0);
    check_eq("rst_prdata0", prdata0, 32'h0);
    check_eq("rst_pready3", {31'b0, pready3}, 32'h0);
    check_eq("rst_prdata3", prdata3, 32'h0);
    Hresetn = 1'b1;
    @(posedge Hclk);
    #1;

    xfer("id_rd0", 0, 1'b0, BASE, 32'h0);
    xfer("wr_r1", 0, 1'b1, BASE + 4, 32'hDEAD_BEEF);
    xfer("rd_r1", 0, 1'b0, BASE + 4, 32'h0);
    xfer("rd_r2", 0, 1'b0, BASE + 8, 32'h0);

    xfer("ws3_rd_r2", 1, 1'b0, BASE + 8, 32'h0);
    xfer("ws3_id", 1, 1'b0, BASE, 32'h0);

    xfer("wr_id", 0, 1'b1, BASE, 32'hFFFF_0000);
    xfer("rd_id_after", 0, 1'b0, BASE, 32'h0);
    xfer("wr_oor", 0, 1'b1, BASE + NREG * 4, 32'h1111_2222);
    xfer("rd_oor", 0, 1'b0, BASE + NREG * 4, 32'h0);
    xfer("rd_misalign", 0, 1'b0, BASE + 6, 32'h0);
    xfer("wr_below", 0, 1'b1, BASE - 4, 32'h3333_4444);
    xfer("rd_top", 0, 1'b0, BASE + (NREG - 1) * 4, 32'h0);

    xfer("b2b_wr0", 0, 1'b1, BASE + 12, 32'hCAFE_0012);
    xfer("b2b_rd0", 0, 1'b0, BASE + 12, 32'h0);
    xfer("b2b_wr3", 1, 1'b1, BASE + 12, 32'h0BAD_F00D);
    xfer("b2b_rd3", 1, 1'b0, BASE + 12, 32'h0);

    // Penable without a setup phase must not start a transfer
    dsel = 1'b0;
    psel = 2'b01;
    Penable = 1'b1;
    Pwrite  = 1'b1;
    Paddr   = BASE + 16;
    Pwdata  = 32'h5555_AAAA;
    @(posedge Hclk);
    @(negedge Hclk);
    check_eq("idle_penable_pready", {31'b0, pready0}, 32'h0);
    @(posedge Hclk);
    #1 psel = 2'b00;
    Penable = 1'b0;
    xfer("idle_penable_rd", 0, 1'b0, BASE + 16, 32'h0);

    // abort in WAIT: Psel dropped after one access cycle
    dsel = 1'b1;
    psel = 2'b10;
    Pwrite = 1'b1;
    Paddr  = BASE + 16;
    Pwdata = 32'hA5A5_A5A5;
    @(posedge Hclk);
    #1 Penable = 1'b1;
    @(posedge Hclk);
    #1 psel = 2'b00;
    Penable = 1'b0;
    @(negedge Hclk);
    check_eq("abort_pready", {31'b0, pready3}, 32'h0);
    @(posedge Hclk);
    #1;
    xfer("abort_rd", 1, 1'b0, BASE + 16, 32'h0);

    // reset asserted mid-WAIT
    xfer("pre_rst_wr", 1, 1'b1, BASE + 4, 32'h1234_5678);
    xfer("pre_rst_rd", 1, 1'b0, BASE + 4, 32'h0);
    dsel   = 1'b1;
    psel   = 2'b10;
    Pwrite = 1'b1;
    Paddr  = BASE + 8;
    Pwdata = 32'h0000_FFFF;
    @(posedge Hclk);
    #1 Penable = 1'b1;
    @(posedge Hclk);
    #1 Hresetn = 1'b0;
    #1;
    check_eq("midrst_pready", {31'b0, pready3}, 32'h0);
    check_eq("midrst_prdata3", prdata3, 32'h0);
    check_eq("midrst_prdata0", prdata0, 32'h0);
    psel    = 2'b00;
    Penable = 1'b0;
    clear_model();
    @(posedge Hclk);
    #1 Hresetn = 1'b1;
    @(posedge Hclk);
    #1;
    for (int r = 1; r < NREG; r++) begin
      xfer($sformatf("post_rst_r%0d", r), 1, 1'b0, BASE + 32'(r * 4), 32'h0);
    end
    xfer("post_rst_d0_r1", 0, 1'b0, BASE + 4, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
